// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state/class encodings and output selects for the multicycle sequencer
package mc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SLLM  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_BREAK = 6'b001101;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE,
        S_EXEC, S_WB, S_LONG, S_MEM_ADDR,
        S_MEM_WAIT, S_STORE, S_BRANCH, S_JUMP,
        S_EXC, S_EXC_WAIT, S_EXC_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LONG, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_HALT, CL_UNKNOWN
    } op_class_t;

    localparam logic [1:0] EXC_NONE   = 2'd0;
    localparam logic [1:0] EXC_OPCODE = 2'd1;
    localparam logic [1:0] EXC_OVF    = 2'd2;
    localparam logic [1:0] EXC_DIV0   = 2'd3;

    localparam logic [2:0] MA_PC     = 3'd0;
    localparam logic [2:0] MA_ALUOUT = 3'd1;

    localparam logic [1:0] PS_ALU    = 2'd0;
    localparam logic [1:0] PS_ALUOUT = 2'd1;
    localparam logic [1:0] PS_JUMP   = 2'd2;
    localparam logic [1:0] PS_MEM    = 2'd3;

    function automatic logic [2:0] vec_sel(input logic [1:0] exc);
        return 3'(exc) + 3'd1;
    endfunction
endpackage

// File: rtl/op_class_dec.sv
// op_class_dec: Opcode/Funct to instruction class and overflow-check flag; MULDIV_EN decodes mult/div as LONG
module op_class_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class,
    output logic       ovf_chk
);
    always_comb begin
        op_class = CL_UNKNOWN;
        ovf_chk  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB: begin
                        op_class = CL_ALU;
                        ovf_chk  = 1'b1;
                    end
                    FN_AND, FN_SLT, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRAV, FN_MFHI, FN_MFLO: op_class = CL_ALU;
`ifdef MULDIV_EN
                    FN_MULT, FN_DIV: op_class = CL_LONG;
`else
                    FN_MULT, FN_DIV: op_class = CL_UNKNOWN;
`endif
                    FN_JR:    op_class = CL_JUMP;
                    FN_BREAK: op_class = CL_HALT;
                    default:  op_class = CL_UNKNOWN;
                endcase
            end
            OP_ADDI: begin
                op_class = CL_ALU;
                ovf_chk  = 1'b1;
            end
            OP_ADDIU, OP_SLTI, OP_LUI:      op_class = CL_ALU;
            OP_LB, OP_LH, OP_LW, OP_SLLM:   op_class = CL_LOAD;
            OP_SB, OP_SH, OP_SW:            op_class = CL_STORE;
            OP_BEQ, OP_BNE, OP_BLE, OP_BGT: op_class = CL_BRANCH;
            OP_J, OP_JAL:                   op_class = CL_JUMP;
            default:                        op_class = CL_UNKNOWN;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_seq.sv
// mc_ctrl_seq: multicycle MIPS-subset control sequencer; LONG (mult/div) path present only when MULDIV_EN is defined
module mc_ctrl_seq
    import mc_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       Reset_In,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Overflow,
    input  logic       Zero_Div,
    output logic [2:0] Mux_Address,
    output logic [1:0] pc_src,
    output logic       IR_Load,
    output logic       A_Load,
    output logic       B_Load,
    output logic       ALUOut_Load,
    output logic       MDR_Load,
    output logic       EPC_Load,
    output logic       High_Load,
    output logic       Low_Load,
    output logic       PCWrite,
    output logic       Reg_WR,
    output logic       Memory_WR,
    output logic       is_branch,
    output logic [1:0] exc_code,
    output logic       instr_done,
    output logic       Reset_Out,
    output logic [3:0] state
);
    localparam int CNT_MAX = DATA_W > MEM_LAT ? DATA_W : MEM_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t         st, nx;
    op_class_t      cls;
    logic           ovf_chk;
    logic [CW-1:0]  cnt;
    logic [1:0]     exc_q, exc_nx;
    logic           last, long_exc, long_done, in_exc;

    op_class_dec u_dec (
        .opcode   (Opcode),
        .funct    (Funct),
        .op_class (cls),
        .ovf_chk  (ovf_chk)
    );

    assign last      = cnt <= CW'(1);
    assign long_exc  = st == S_LONG && cnt == CW'(DATA_W) && Funct == FN_DIV && Zero_Div;
    assign long_done = st == S_LONG && last && !long_exc;
    assign in_exc    = st inside {S_EXC, S_EXC_WAIT};
    assign state     = st;

    always_ff @(posedge clk) begin
        if (Reset_In) begin
            st    <= S_RESET;
            cnt   <= '0;
            exc_q <= EXC_NONE;
        end else begin
            st    <= nx;
            exc_q <= exc_nx;
            if (st inside {S_FETCH, S_MEM_ADDR, S_EXC})
                cnt <= CW'(MEM_LAT);
            else if (st == S_DECODE && cls == CL_LONG)
                cnt <= CW'(DATA_W);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        nx     = st;
        exc_nx = exc_q;
        case (st)
            S_RESET:      nx = S_FETCH;
            S_FETCH:      nx = S_FETCH_WAIT;
            S_FETCH_WAIT: nx = last ? S_DECODE : S_FETCH_WAIT;
            S_DECODE: begin
                nx = cls == CL_ALU                       ? S_EXEC     :
                     cls == CL_LONG                      ? S_LONG     :
                     cls inside {CL_LOAD, CL_STORE}      ? S_MEM_ADDR :
                     cls == CL_BRANCH                    ? S_BRANCH   :
                     cls == CL_JUMP                      ? S_JUMP     :
                     cls == CL_HALT                      ? S_HALT     : S_EXC;
                exc_nx = cls == CL_UNKNOWN ? EXC_OPCODE : EXC_NONE;
            end
            S_EXEC: begin
                nx     = ovf_chk && Overflow ? S_EXC : S_WB;
                exc_nx = ovf_chk && Overflow ? EXC_OVF : EXC_NONE;
            end
            S_LONG: begin
                nx     = long_exc ? S_EXC : last ? S_FETCH : S_LONG;
                exc_nx = long_exc ? EXC_DIV0 : EXC_NONE;
            end
            S_MEM_ADDR:   nx = cls == CL_LOAD ? S_MEM_WAIT : S_STORE;
            S_MEM_WAIT:   nx = last ? S_WB : S_MEM_WAIT;
            S_EXC:        nx = S_EXC_WAIT;
            S_EXC_WAIT:   nx = last ? S_EXC_JUMP : S_EXC_WAIT;
            S_HALT:       nx = S_HALT;
            default:      nx = S_FETCH;
        endcase
    end

    always_comb begin
        Reset_Out   = st == S_RESET;
        Mux_Address = in_exc ? vec_sel(exc_q) : st inside {S_MEM_WAIT, S_STORE} ? MA_ALUOUT : MA_PC;
        pc_src      = st == S_EXC_JUMP ? PS_MEM :
                      st == S_JUMP     ? (Opcode == OP_RTYPE ? PS_ALUOUT : PS_JUMP) :
                      st == S_BRANCH   ? PS_ALUOUT : PS_ALU;
        IR_Load     = st == S_FETCH_WAIT && last;
        A_Load      = st == S_DECODE;
        B_Load      = st == S_DECODE;
        ALUOut_Load = st inside {S_DECODE, S_EXEC, S_MEM_ADDR};
        MDR_Load    = st == S_MEM_WAIT && last;
        EPC_Load    = st == S_EXC;
        High_Load   = long_done;
        Low_Load    = long_done;
        PCWrite     = st inside {S_FETCH, S_JUMP, S_EXC_JUMP};
        Reg_WR      = st == S_WB || (st == S_JUMP && Opcode == OP_JAL);
        Memory_WR   = st == S_STORE;
        is_branch   = st == S_BRANCH;
        exc_code    = in_exc || st == S_EXC_JUMP ? exc_q : EXC_NONE;
        instr_done  = st inside {S_WB, S_STORE, S_BRANCH, S_JUMP, S_EXC_JUMP} || long_done;
    end
endmodule
